vio_debug_core: RTL and testbench

//   Synthesizable virtual-I/O debug core for the single-cycle RISC-V top level.

---
 rtl/vio_pkg.sv | 38 +++
 rtl/vio_debug_core_sync.sv | 34 +++
 rtl/vio_debug_core.sv | 152 +++++++++++++++
 tb/tb_vio_debug_core.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vio_pkg.sv
// Shared constants for the virtual-I/O debug core: host register map,
// core ID word and the per-probe width table.
package vio_pkg;

  localparam int NUM_PROBES = 13;

  // Host register map
  localparam logic [4:0] ADDR_OUT0 = 5'd13;
  localparam logic [4:0] ADDR_OUT1 = 5'd14;
  localparam logic [4:0] ADDR_ID   = 5'd15;
  localparam logic [4:0] ADDR_ACT  = 5'd16;

  // "VIO" followed by the probe count
  localparam logic [31:0] VIO_ID = 32'h56494F0D;

  // Width of each probe input, indexed by probe number
  function automatic int probe_width(input int idx);
    case (idx)
      0, 1, 2: return 1;
      8:       return 4;
      12:      return 5;
      default: return 32;
    endcase
  endfunction

  // Bit offset of each probe inside the flattened probe bus
  function automatic int probe_lsb(input int idx);
    int acc;
    acc = 0;
    for (int i = 0; i < idx; i++) begin
      acc += probe_width(i);
    end
    return acc;
  endfunction

  localparam int PROBE_BITS = probe_lsb(NUM_PROBES);

endpackage

// File: rtl/vio_debug_core_sync.sv
// Multi-stage synchronizer for one probe. Every stage is cleared by the
// asynchronous reset so the snapshot starts from a known all-zero value.
module vio_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_reg [STAGES];

  // First stage samples the asynchronous probe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stage_reg[0] <= '0;
    else       stage_reg[0] <= d;
  end

  genvar gi;
  generate
    for (gi = 1; gi < STAGES; gi++) begin : g_stage
      // Each further stage resolves metastability of the one before it
      always_ff @(posedge clk or posedge reset) begin
        if (reset) stage_reg[gi] <= '0;
        else       stage_reg[gi] <= stage_reg[gi-1];
      end
    end
  endgenerate

  assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/vio_debug_core.sv
// Virtual-I/O debug core: synchronises 13 CPU probes into a freezable
// snapshot, exposes them plus two host-settable override outputs through a
// small register-mapped host port.
// Optional feature macro: VIO_ACTIVITY_EN (sticky per-probe change flags at
// address 16; without it address 16 reads zero).
module vio_debug_core
  import vio_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] INIT_OUT0   = 32'h0,
  parameter logic        INIT_OUT1   = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              probe_in0,
  input  logic              probe_in1,
  input  logic              probe_in2,
  input  logic [31:0]       probe_in3,
  input  logic [31:0]       probe_in4,
  input  logic [31:0]       probe_in5,
  input  logic [31:0]       probe_in6,
  input  logic [31:0]       probe_in7,
  input  logic [3:0]        probe_in8,
  input  logic [31:0]       probe_in9,
  input  logic [31:0]       probe_in10,
  input  logic [31:0]       probe_in11,
  input  logic [4:0]        probe_in12,
  output logic [DATA_W-1:0] probe_out0,
  output logic              probe_out1,
  input  logic [4:0]        host_addr,
  input  logic              host_rd,
  input  logic              host_wr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_hold,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid
);

  // A single synchronizer stage would not be safe; clamp to two
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [PROBE_BITS-1:0] probe_flat;
  logic [DATA_W-1:0]     synced   [NUM_PROBES];
  logic [DATA_W-1:0]     snap_reg [NUM_PROBES];
  logic [DATA_W-1:0]     act_word;
  logic [DATA_W-1:0]     rd_value;

  assign probe_flat = {probe_in12, probe_in11, probe_in10, probe_in9,
                       probe_in8,  probe_in7,  probe_in6,  probe_in5,
                       probe_in4,  probe_in3,  probe_in2,  probe_in1,
                       probe_in0};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PROBES; gi++) begin : g_probe
      localparam int W   = probe_width(gi);
      localparam int LSB = probe_lsb(gi);
      logic [W-1:0] sync_q;

      vio_sync #(
        .WIDTH  (W),
        .STAGES (STAGES)
      ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (probe_flat[LSB +: W]),
        .q     (sync_q)
      );

      assign synced[gi] = DATA_W'(sync_q);
    end
  endgenerate

  // Snapshot follows the synchronised probes unless the host freezes it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PROBES; i++) snap_reg[i] <= '0;
    end else if (!host_hold) begin
      for (int i = 0; i < NUM_PROBES; i++) snap_reg[i] <= synced[i];
    end
  end

`ifdef VIO_ACTIVITY_EN
  logic [DATA_W-1:0]     prev_reg [NUM_PROBES];
  logic [NUM_PROBES-1:0] flags_reg;
  logic [NUM_PROBES-1:0] change;
  logic                  act_clr;

  assign act_clr = host_rd && (host_addr == ADDR_ACT);

  // A probe is active when its synced value moved since the previous cycle
  always_comb begin
    change = '0;
    for (int i = 0; i < NUM_PROBES; i++) change[i] = (synced[i] != prev_reg[i]);
  end

  // Sticky flags ignore hold; a read clears them but a coincident change wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PROBES; i++) prev_reg[i] <= '0;
      flags_reg <= '0;
    end else begin
      for (int i = 0; i < NUM_PROBES; i++) prev_reg[i] <= synced[i];
      flags_reg <= (act_clr ? '0 : flags_reg) | change;
    end
  end

  assign act_word = DATA_W'(flags_reg);
`else
  assign act_word = '0;
`endif

  // Read mux over the current (pre-write) register contents
  always_comb begin
    rd_value = '0;
    if (host_addr < ADDR_OUT0) begin
      rd_value = snap_reg[host_addr[3:0]];
    end else begin
      case (host_addr)
        ADDR_OUT0: rd_value = probe_out0;
        ADDR_OUT1: rd_value = DATA_W'(probe_out1);
        ADDR_ID:   rd_value = DATA_W'(VIO_ID);
        ADDR_ACT:  rd_value = act_word;
        default:   rd_value = '0;
      endcase
    end
  end

  // Registered read data with a one-cycle valid pulse; data holds between reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
    end else begin
      host_rvalid <= host_rd;
      if (host_rd) host_rdata <= rd_value;
    end
  end

  // Host-writable override outputs, driven straight from flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      probe_out0 <= DATA_W'(INIT_OUT0);
      probe_out1 <= INIT_OUT1;
    end else if (host_wr) begin
      if (host_addr == ADDR_OUT0) probe_out0 <= host_wdata;
      if (host_addr == ADDR_OUT1) probe_out1 <= host_wdata[0];
    end
  end

endmodule

// File: tb/tb_vio_debug_core.sv
// Self-checking bench for vio_debug_core: directed register-map scenarios
// followed by randomised probe/host traffic, all compared against a
// cycle-level reference model. Honours VIO_ACTIVITY_EN when defined.
module tb_vio_debug_core;

  localparam logic [31:0] INIT0  = 32'hA5A5_0001;
  localparam logic [31:0] ID_VAL = 32'h56494F0D;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pin [13];
  logic [31:0] probe_out0;
  logic        probe_out1;
  logic [4:0]  host_addr;
  logic        host_rd, host_wr, host_hold;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata;
  logic        host_rvalid;

  int tests  = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_snap [13];
  logic [31:0] d1 [13];   // probe value seen at the previous edge
  logic [31:0] d2 [13];   // two edges ago
  logic [31:0] d3 [13];   // three edges ago
  logic [12:0] m_flags;
  logic [31:0] m_out0, m_rdata;
  logic        m_out1, m_rvalid;

  always #5 clk = ~clk;

  vio_debug_core #(
    .DATA_W      (32),
    .SYNC_STAGES (2),
    .INIT_OUT0   (INIT0),
    .INIT_OUT1   (1'b0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .probe_in0   (pin[0][0]),
    .probe_in1   (pin[1][0]),
    .probe_in2   (pin[2][0]),
    .probe_in3   (pin[3]),
    .probe_in4   (pin[4]),
    .probe_in5   (pin[5]),
    .probe_in6   (pin[6]),
    .probe_in7   (pin[7]),
    .probe_in8   (pin[8][3:0]),
    .probe_in9   (pin[9]),
    .probe_in10  (pin[10]),
    .probe_in11  (pin[11]),
    .probe_in12  (pin[12][4:0]),
    .probe_out0  (probe_out0),
    .probe_out1  (probe_out1),
    .host_addr   (host_addr),
    .host_rd     (host_rd),
    .host_wr     (host_wr),
    .host_wdata  (host_wdata),
    .host_hold   (host_hold),
    .host_rdata  (host_rdata),
    .host_rvalid (host_rvalid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] width_mask(input int n);
    case (n)
      0, 1, 2: return 32'h1;
      8:       return 32'hF;
      12:      return 32'h1F;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a < 5'd13) return m_snap[a];
    case (a)
      5'd13: return m_out0;
      5'd14: return {31'b0, m_out1};
      5'd15: return ID_VAL;
`ifdef VIO_ACTIVITY_EN
      5'd16: return {19'b0, m_flags};
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 13; n++) begin
      m_snap[n] = '0; d1[n] = '0; d2[n] = '0; d3[n] = '0;
    end
    m_flags  = '0;
    m_out0   = INIT0;
    m_out1   = 1'b0;
    m_rdata  = '0;
    m_rvalid = 1'b0;
  endtask

  // One clock edge: advance the model with the inputs present at the edge,
  // then compare every host-visible output just after the edge.
  task automatic tick();
    logic [31:0] rv;
    logic [31:0] cur [13];
    rv = model_read(host_addr);
    for (int n = 0; n < 13; n++) cur[n] = pin[n] & width_mask(n);
    @(posedge clk);
    m_rvalid = host_rd;
    if (host_rd) m_rdata = rv;
    if (host_rd && host_addr == 5'd16) m_flags = '0;
    for (int n = 0; n < 13; n++) if (d2[n] != d3[n]) m_flags[n] = 1'b1;
    if (!host_hold) for (int n = 0; n < 13; n++) m_snap[n] = d2[n];
    if (host_wr && host_addr == 5'd13) m_out0 = host_wdata;
    if (host_wr && host_addr == 5'd14) m_out1 = host_wdata[0];
    for (int n = 0; n < 13; n++) begin
      d3[n] = d2[n]; d2[n] = d1[n]; d1[n] = cur[n];
    end
    #1;
    check("rdata",  host_rdata,          m_rdata);
    check("rvalid", {31'b0, host_rvalid}, {31'b0, m_rvalid});
    check("out0",   probe_out0,          m_out0);
    check("out1",   {31'b0, probe_out1},  {31'b0, m_out1});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic host_read(input logic [4:0] a);
    host_addr = a; host_rd = 1'b1;
    tick();
    host_rd = 1'b0;
    $display("[TB] read  addr %0d -> %h", a, host_rdata);
  endtask

  task automatic host_write(input logic [4:0] a, input logic [31:0] v);
    host_addr = a; host_wr = 1'b1; host_wdata = v;
    tick();
    host_wr = 1'b0;
    $display("[TB] write addr %0d <- %h", a, v);
  endtask

  initial begin
    reset = 1'b1;
    host_addr = '0; host_rd = 1'b0; host_wr = 1'b0; host_wdata = '0; host_hold = 1'b0;
    for (int n = 0; n < 13; n++) pin[n] = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_out0",   probe_out0,           INIT0);
    check("reset_out1",   {31'b0, probe_out1},   32'h0);
    check("reset_rdata",  host_rdata,           32'h0);
    check("reset_rvalid", {31'b0, host_rvalid},  32'h0);
    @(negedge clk);
    reset = 1'b0;

    // ID register
    host_read(5'd15);
    check("id", host_rdata, ID_VAL);

    // Instruction probe through synchronizer + snapshot
    pin[6] = 32'h002081D3;
    idle(4);
    host_read(5'd6);
    check("probe6", host_rdata, 32'h002081D3);
    check("probe6_rvalid", {31'b0, host_rvalid}, 32'h1);
    tick();
    check("rvalid_pulse", {31'b0, host_rvalid}, 32'h0);
    check("rdata_hold", host_rdata, 32'h002081D3);

    // Narrow probe zero-extended
    pin[8] = 32'hF;
    idle(4);
    host_read(5'd8);
    check("probe8_zext", host_rdata, 32'h0000000F);

    // Override outputs
    host_write(5'd13, 32'h0000_0007);
    host_write(5'd14, 32'hFFFF_FFFF);
    check("out0_wr", probe_out0, 32'h7);
    check("out1_wr", {31'b0, probe_out1}, 32'h1);
    host_read(5'd14);
    check("out1_rd", host_rdata, 32'h1);

    // Read and write the same address together: pre-write value returned
    host_addr = 5'd13; host_rd = 1'b1; host_wr = 1'b1; host_wdata = 32'hDEAD_BEEF;
    tick();
    host_rd = 1'b0; host_wr = 1'b0;
    check("rw_prewrite", host_rdata, 32'h7);
    check("rw_written", probe_out0, 32'hDEAD_BEEF);

    // Hold freezes the snapshot
    pin[5] = 32'h0;
    idle(4);
    host_hold = 1'b1;
    pin[5] = 32'h5;
    idle(4);
    host_read(5'd5);
    check("hold_frozen", host_rdata, 32'h0);
    host_hold = 1'b0;
    idle(3);
    host_read(5'd5);
    check("hold_release", host_rdata, 32'h5);

    // Activity flags
    idle(5);
    host_read(5'd16);
    pin[1] = pin[1] ^ 32'h1;
    idle(4);
    host_read(5'd16);
`ifdef VIO_ACTIVITY_EN
    check("act_set", host_rdata, 32'h2);
`else
    check("act_off", host_rdata, 32'h0);
`endif
    host_read(5'd16);
    check("act_clear", host_rdata, 32'h0);

    // Writes to read-only and unused addresses are ignored
    host_write(5'd3,  32'h1234_5678);
    host_write(5'd20, 32'h8765_4321);
    check("ro_out0", probe_out0, 32'hDEAD_BEEF);
    check("ro_out1", {31'b0, probe_out1}, 32'h1);
    host_read(5'd3);
    check("ro_probe3", host_rdata, 32'h0);
    host_read(5'd20);
    check("unused_rd", host_rdata, 32'h0);

    // Randomised traffic against the model
    for (int c = 0; c < 600; c++) begin
      for (int n = 0; n < 13; n++)
        if ($urandom_range(0, 7) == 0) pin[n] = $urandom() & width_mask(n);
      host_hold  = ($urandom_range(0, 7) == 0);
      host_rd    = $urandom_range(0, 1);
      host_wr    = ($urandom_range(0, 3) == 0);
      host_addr  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                               : 5'($urandom_range(0, 16));
      host_wdata = $urandom();
      tick();
    end
    host_rd = 1'b0; host_wr = 1'b0; host_hold = 1'b0;

    // Reset asserted while a read result is being presented
    host_read(5'd15);
    reset = 1'b1;
    #1;
    check("midread_rvalid", {31'b0, host_rvalid}, 32'h0);
    check("midread_rdata",  host_rdata,          32'h0);
    check("midread_out0",   probe_out0,          INIT0);
    check("midread_out1",   {31'b0, probe_out1},  32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
